alu_share_ctrl: RTL
===================

// Module: alu_share_ctrl
// PURPOSE
//  Shares one 4-bit ALU instance between NUM_REQ requesters.
//  - Round-robin arbitration; valid/ready handshake per requester.
//  - 2-stage pipeline: operand register -> ALU -> response register.
//  - Tagged responses on a single output port with backpressure.
//  - Sits between the issuing blocks and the combinational alu datapath.
// PARAMETERS
//  NUM_REQ  2   number of requesters, legal 2..4
//  ID_W     1   response tag width, = $clog2(NUM_REQ), derived, not overridden
//  CNT_W    16  width of completed-operation counter
// PORTS
//  clk         in   1            single clock, rising edge
//  rst_n       in   1            asynchronous, active-low reset
//  req_valid   in   NUM_REQ      requester i has an operation pending
//  req_ready   out  NUM_REQ      one-hot or zero; transfer when valid & ready
//  req_a       in   NUM_REQ*4    operand A, slice [4i+3:4i]
//  req_b       in   NUM_REQ*4    operand B, slice [4i+3:4i]
//  req_op      in   NUM_REQ*3    alu_ctrl code, slice [3i+2:3i]
//  rsp_valid   out  1            response register holds a result
//  rsp_ready   in   1            consumer accepts; transfer when valid & ready
//  rsp_id      out  ID_W         index of the originating requester
//  rsp_result  out  4            ALU result
//  rsp_carry   out  1            ALU carry_out
//  rsp_zero    out  1            ALU zero flag
//  busy        out  1            either pipeline stage occupied
//  ops_done    out  CNT_W        count of completed response transfers, wraps
// BEHAVIOUR
//  Reset values: all outputs 0; rr pointer = 0; both stage valids = 0.
//  - Reset asserted mid-operation: all in-flight operations are discarded silently.
//  Op codes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL1, 110 SHR1, 111 PASS A.
//  - ADD/SUB use 5-bit arithmetic: result = tmp[3:0], carry = tmp[4].
//  - SUB carry is the borrow (1 when a < b).
//  - Non-arithmetic ops: carry = 0. zero = (result == 4'd0) for every op.
//  Stage advance:
//  - s2_adv = !s2_vld | rsp_ready.
//  - s1_adv = !s1_vld | s2_adv.
//  - Accept a request only if s1_adv; with no accept, s1 drains (s1_vld clears when it moves to s2).
//  Arbitration (combinational, same cycle):
//  - Search order starts at ptr and wraps modulo NUM_REQ.
//  - The first valid requester gets req_ready, only while s1_adv is true.
//  - req_ready may depend on req_valid.
//  - On transfer: ptr <= granted+1 (wraps to 0 after NUM_REQ-1); otherwise ptr holds.
//  Requester rules:
//  - Holds valid, a, b and op stable until transfer.
//  - Deasserting valid before transfer is legal; no grant is issued to it.
//  Latency and throughput:
//  - Accept at edge N -> rsp_valid at edge N+2 with rsp_ready high.
//  - Throughput 1 op/cycle.
//  - Responses leave in acceptance order.
//  Backpressure:
//  - rsp_valid=1 & rsp_ready=0: all rsp_* outputs hold stable.
//  - s1 fills, then every req_ready=0.
//  - Nothing is dropped or duplicated.
//  Simultaneous events: a response drain and a new accept in the same cycle are legal (full-rate flow).
//  ops_done increments on each rsp transfer and wraps 2^CNT_W-1 -> 0.
//  busy = s1_vld | s2_vld.
// STRUCTURE
//  Package alu_pkg:
//  - typedef enum logic[2:0] alu_op_e (ALU_ADD..ALU_PASS).
//  - localparam ALU_W = 4.
//  - typedef struct {a, b, op, id} alu_req_t.
//  Sub-module: one instance of the existing combinational alu, fed from the s1 register.
//  Arbiter, pipeline registers and counter are inline; rr_arbiter may be split out if reused.
// TESTING
//  1 req0: a=9, b=8, ADD -> two cycles later rsp_id=0, result=1, carry=1, zero=0.
//  2 req1: a=3, b=5, SUB -> result=14, carry=1. Then a=5, b=5, SUB -> result=0, carry=0, zero=1.
//  3 Both valid continuously, rsp_ready=1 -> grants and rsp_id alternate 0,1,0,1; one op/cycle.
//  4 rsp_ready=0 for 3 cycles with 2 ops in flight:
//    - rsp_* stable, req_ready=0, busy=1.
//    - On release: both responses back-to-back, in order, ops_done += 2.
//  5 rst_n low while s1 and s2 are valid:
//    - All outputs 0 immediately.
//    - After release, with both requesting, the first grant goes to req0.
//  6 500 random ops and stalls vs a scoreboard model covering every op:
//    - SHL a=9 -> 2, carry=0.
//    - SHR a=1 -> 0, zero=1.
//    - Counter wrap checked by forcing CNT_W=4.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the shared-ALU controller: op codes, datapath width and
// the request record carried through the operand stage.
package alu_pkg;

    localparam int ALU_W    = 4;
    localparam int ID_MAX_W = 2;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_SHL  = 3'b101,
        ALU_SHR  = 3'b110,
        ALU_PASS = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic [ALU_W-1:0]    a;
        logic [ALU_W-1:0]    b;
        alu_op_e             op;
        logic [ID_MAX_W-1:0] id;
    } alu_req_t;

endpackage

// File: rtl/alu.sv
// Combinational 4-bit ALU; carry is the ADD carry-out or SUB borrow,
// zero for every other op.
module alu
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  alu_op_e          op,
    output logic [ALU_W-1:0] result,
    output logic             carry,
    output logic             zero
);

    logic [ALU_W:0] tmp;

    always_comb begin
        tmp    = '0;
        result = '0;
        carry  = 1'b0;
        case (op)
            ALU_ADD: begin
                tmp    = {1'b0, a} + {1'b0, b};
                result = tmp[ALU_W-1:0];
                carry  = tmp[ALU_W];
            end
            ALU_SUB: begin
                tmp    = {1'b0, a} - {1'b0, b};
                result = tmp[ALU_W-1:0];
                carry  = tmp[ALU_W];
            end
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SHL:  result = {a[ALU_W-2:0], 1'b0};
            ALU_SHR:  result = {1'b0, a[ALU_W-1:1]};
            ALU_PASS: result = a;
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin sharing of one ALU between NUM_REQ requesters through an
// operand register and a response register, with response backpressure.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*ALU_W-1:0] req_a,
    input  logic [NUM_REQ*ALU_W-1:0] req_b,
    input  logic [NUM_REQ*3-1:0]     req_op,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [ALU_W-1:0]         rsp_result,
    output logic                     rsp_carry,
    output logic                     rsp_zero,
    output logic                     busy,
    output logic [CNT_W-1:0]         ops_done
);

    logic            s1_vld;
    logic            s2_vld;
    alu_req_t        s1_req;
    alu_req_t        sel_req;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] grant_idx;
    logic            grant_found;
    logic            accept;
    logic            s1_adv;
    logic            s2_adv;

    logic [ALU_W-1:0] alu_result;
    logic             alu_carry;
    logic             alu_zero;

    assign s2_adv = !s2_vld || rsp_ready;
    assign s1_adv = !s1_vld || s2_adv;

    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
    end

    // Gated by rst_n so req_ready reads 0 for the whole reset window.
    assign accept = grant_found && s1_adv && rst_n;

    always_comb begin
        req_ready = '0;
        if (accept)
            req_ready[grant_idx] = 1'b1;
    end

    always_comb begin
        sel_req.a  = req_a[grant_idx*ALU_W +: ALU_W];
        sel_req.b  = req_b[grant_idx*ALU_W +: ALU_W];
        sel_req.op = alu_op_e'(req_op[grant_idx*3 +: 3]);
        sel_req.id = ID_MAX_W'(grant_idx);
    end

    alu u_alu (
        .a      (s1_req.a),
        .b      (s1_req.b),
        .op     (s1_req.op),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld     <= 1'b0;
            s2_vld     <= 1'b0;
            s1_req     <= '0;
            ptr        <= '0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
            ops_done   <= '0;
        end else begin
            if (s1_adv) begin
                s1_vld <= accept;
                if (accept)
                    s1_req <= sel_req;
            end
            if (accept)
                ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            // Response register only loads when s1 carries a real operation.
            if (s2_adv) begin
                s2_vld <= s1_vld;
                if (s1_vld) begin
                    rsp_id     <= ID_W'(s1_req.id);
                    rsp_result <= alu_result;
                    rsp_carry  <= alu_carry;
                    rsp_zero   <= alu_zero;
                end
            end
            if (s2_vld && rsp_ready)
                ops_done <= ops_done + 1'b1;
        end
    end

    assign rsp_valid = s2_vld;
    assign busy      = s1_vld || s2_vld;

endmodule
